// File: rtl/cle_label_stats.sv
// Reads the 32x32 labelled image back from the CLE result SRAM and accumulates per-label
// pixel count and bounding box, then streams one record per object over valid/ready.
module cle_label_stats #(
   parameter int unsigned MAX_OBJ = 8,
   parameter int unsigned AW      = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [AW-1:0]     sram_a,
   output logic              sram_wen,
   input  logic [7:0]        sram_q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_label,
   output logic [AW:0]       out_count,
   output logic [AW/2-1:0]   out_rmin,
   output logic [AW/2-1:0]   out_rmax,
   output logic [AW/2-1:0]   out_cmin,
   output logic [AW/2-1:0]   out_cmax,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int unsigned HW   = AW / 2;
   localparam int unsigned CW   = AW + 1;
   localparam int unsigned IW   = $clog2(MAX_OBJ + 1);
   localparam int          NOBJ = int'(MAX_OBJ);
   localparam logic [CW-1:0] CNT_MAX = CW'(1 << AW);
   localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_EMIT  = 2'd3;

   typedef struct packed {
      logic          vld;
      logic [7:0]    label;
      logic [CW-1:0] count;
      logic [HW-1:0] rmin;
      logic [HW-1:0] rmax;
      logic [HW-1:0] cmin;
      logic [HW-1:0] cmax;
   } entry_t;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] sram_a_d;
   logic          pipe_vld_q, pipe_vld_d;
   logic [AW-1:0] pipe_addr_q, pipe_addr_d;
   logic [IW-1:0] emit_idx_q, emit_idx_d;
   logic          out_valid_d;
   logic [7:0]    out_label_d;
   logic [CW-1:0] out_count_d;
   logic [HW-1:0] out_rmin_d, out_rmax_d, out_cmin_d, out_cmax_d;
   logic          busy_d, done_d, overflow_d;
   entry_t        tbl_q [MAX_OBJ];
   entry_t        tbl_d [MAX_OBJ];

   logic [MAX_OBJ-1:0] hit;
   logic               free_ok;
   logic [IW-1:0]      free_idx;
   logic               emit_ok;
   logic [HW-1:0]      pix_row, pix_col;

   assign pix_row = pipe_addr_q[AW-1:HW];
   assign pix_col = pipe_addr_q[HW-1:0];

   // Parallel label compare and lowest-free-slot search over the whole table.
   always_comb begin
      hit      = '0;
      free_ok  = 1'b0;
      free_idx = '0;
      for (int i = 0; i < NOBJ; i++) begin
         hit[i] = tbl_q[i].vld && (tbl_q[i].label == sram_q);
      end
      for (int i = NOBJ - 1; i >= 0; i--) begin
         if (!tbl_q[i].vld) begin
            free_ok  = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   // Next-state, table update and output staging.
   always_comb begin
      state_d     = state_q;
      sram_a_d    = sram_a;
      pipe_vld_d  = 1'b0;
      pipe_addr_d = pipe_addr_q;
      emit_idx_d  = emit_idx_q;
      out_valid_d = out_valid;
      out_label_d = out_label;
      out_count_d = out_count;
      out_rmin_d  = out_rmin;
      out_rmax_d  = out_rmax;
      out_cmin_d  = out_cmin;
      out_cmax_d  = out_cmax;
      done_d      = 1'b0;
      overflow_d  = overflow;
      emit_ok     = 1'b0;
      tbl_d       = tbl_q;

      // Absorb the pixel whose address was issued last cycle.
      if (pipe_vld_q && (sram_q != 8'd0)) begin
         if (|hit) begin
            for (int i = 0; i < NOBJ; i++) begin
               if (hit[i]) begin
                  if (tbl_q[i].count != CNT_MAX) tbl_d[i].count = tbl_q[i].count + CW'(1);
                  if (pix_row < tbl_q[i].rmin) tbl_d[i].rmin = pix_row;
                  if (pix_row > tbl_q[i].rmax) tbl_d[i].rmax = pix_row;
                  if (pix_col < tbl_q[i].cmin) tbl_d[i].cmin = pix_col;
                  if (pix_col > tbl_q[i].cmax) tbl_d[i].cmax = pix_col;
               end
            end
         end else if (free_ok) begin
            for (int i = 0; i < NOBJ; i++) begin
               if (free_idx == IW'(i)) begin
                  tbl_d[i].vld   = 1'b1;
                  tbl_d[i].label = sram_q;
                  tbl_d[i].count = CW'(1);
                  tbl_d[i].rmin  = pix_row;
                  tbl_d[i].rmax  = pix_row;
                  tbl_d[i].cmin  = pix_col;
                  tbl_d[i].cmax  = pix_col;
               end
            end
         end else begin
            overflow_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SCAN;
               overflow_d = 1'b0;
               emit_idx_d = '0;
               sram_a_d   = '0;
               for (int i = 0; i < NOBJ; i++) tbl_d[i] = '0;
            end
         end
         ST_SCAN: begin
            pipe_vld_d  = 1'b1;
            pipe_addr_d = sram_a;
            if (sram_a == ADDR_LAST) state_d = ST_DRAIN;
            else                     sram_a_d = sram_a + AW'(1);
         end
         ST_DRAIN: begin
            state_d  = ST_EMIT;
            sram_a_d = '0;
         end
         ST_EMIT: begin
            // Valid entries are contiguous from index 0, so the first invalid slot ends the stream.
            if (!out_valid || out_ready) begin
               for (int i = 0; i < NOBJ; i++) begin
                  if (tbl_q[i].vld && (emit_idx_q == IW'(i))) begin
                     emit_ok     = 1'b1;
                     out_label_d = tbl_q[i].label;
                     out_count_d = tbl_q[i].count;
                     out_rmin_d  = tbl_q[i].rmin;
                     out_rmax_d  = tbl_q[i].rmax;
                     out_cmin_d  = tbl_q[i].cmin;
                     out_cmax_d  = tbl_q[i].cmax;
                  end
               end
               if (emit_ok) begin
                  out_valid_d = 1'b1;
                  emit_idx_d  = emit_idx_q + IW'(1);
               end else begin
                  out_valid_d = 1'b0;
                  out_label_d = '0;
                  out_count_d = '0;
                  out_rmin_d  = '0;
                  out_rmax_d  = '0;
                  out_cmin_d  = '0;
                  out_cmax_d  = '0;
                  state_d     = ST_IDLE;
                  done_d      = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         sram_a      <= '0;
         sram_wen    <= 1'b1;
         pipe_vld_q  <= 1'b0;
         pipe_addr_q <= '0;
         emit_idx_q  <= '0;
         out_valid   <= 1'b0;
         out_label   <= '0;
         out_count   <= '0;
         out_rmin    <= '0;
         out_rmax    <= '0;
         out_cmin    <= '0;
         out_cmax    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         for (int i = 0; i < NOBJ; i++) tbl_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         sram_a      <= sram_a_d;
         sram_wen    <= 1'b1;
         pipe_vld_q  <= pipe_vld_d;
         pipe_addr_q <= pipe_addr_d;
         emit_idx_q  <= emit_idx_d;
         out_valid   <= out_valid_d;
         out_label   <= out_label_d;
         out_count   <= out_count_d;
         out_rmin    <= out_rmin_d;
         out_rmax    <= out_rmax_d;
         out_cmin    <= out_cmin_d;
         out_cmax    <= out_cmax_d;
         busy        <= busy_d;
         done        <= done_d;
         overflow    <= overflow_d;
         for (int i = 0; i < NOBJ; i++) tbl_q[i] <= tbl_d[i];
      end
   end

endmodule

// File: tb/tb_cle_label_stats.sv
// Randomised and directed bench for cle_label_stats against a raster-order object model.
module tb_cle_label_stats;

   localparam int MAX_OBJ = 8;
   localparam int NPIX    = 1024;

   logic       clk = 1'b0;
   logic       reset, start, out_ready;
   logic [9:0] sram_a;
   logic       sram_wen;
   logic [7:0] sram_q;
   logic       out_valid;
   logic [7:0] out_label;
   logic [10:0] out_count;
   logic [4:0] out_rmin, out_rmax, out_cmin, out_cmax;
   logic       busy, done, overflow;

   cle_label_stats #(.MAX_OBJ(MAX_OBJ), .AW(10)) dut (
      .clk(clk), .reset(reset), .start(start),
      .sram_a(sram_a), .sram_wen(sram_wen), .sram_q(sram_q),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_label(out_label), .out_count(out_count),
      .out_rmin(out_rmin), .out_rmax(out_rmax), .out_cmin(out_cmin), .out_cmax(out_cmax),
      .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [NPIX];
   always @(posedge clk) sram_q <= mem[sram_a];

   int n_vec = 0;
   int n_err = 0;
   bit prev_ovf = 1'b0;

   // Model results
   int         e_n;
   bit         e_ovf;
   logic [7:0] e_label [16];
   int         e_cnt [16], e_rmin [16], e_rmax [16], e_cmin [16], e_cmax [16];

   // Records accepted from the DUT
   int         g_n;
   logic [7:0] g_label [16];
   int         g_cnt [16], g_rmin [16], g_rmax [16], g_cmin [16], g_cmax [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Objects in raster order of first appearance; labels beyond the table set overflow.
   function automatic void build_model();
      e_n   = 0;
      e_ovf = 1'b0;
      for (int a = 0; a < NPIX; a++) begin
         int r, c, f;
         r = a / 32;
         c = a % 32;
         f = -1;
         if (mem[a] != 8'd0) begin
            for (int i = 0; i < e_n; i++) if (e_label[i] == mem[a]) f = i;
            if (f >= 0) begin
               e_cnt[f]++;
               if (r < e_rmin[f]) e_rmin[f] = r;
               if (r > e_rmax[f]) e_rmax[f] = r;
               if (c < e_cmin[f]) e_cmin[f] = c;
               if (c > e_cmax[f]) e_cmax[f] = c;
            end else if (e_n < MAX_OBJ) begin
               e_label[e_n] = mem[a];
               e_cnt[e_n]   = 1;
               e_rmin[e_n]  = r;
               e_rmax[e_n]  = r;
               e_cmin[e_n]  = c;
               e_cmax[e_n]  = c;
               e_n++;
            end else begin
               e_ovf = 1'b1;
            end
         end
      end
   endfunction

   task automatic clear_mem();
      for (int a = 0; a < NPIX; a++) mem[a] = 8'd0;
   endtask

   task automatic fill_rect(input logic [7:0] lb, input int r0, input int r1, input int c0, input int c1);
      for (int r = r0; r <= r1; r++)
         for (int c = c0; c <= c1; c++) mem[r*32 + c] = lb;
   endtask

   task automatic rand_image(input int kmax);
      logic [7:0] pool [16];
      int k;
      k = $urandom_range(1, kmax);
      for (int i = 0; i < k; i++) pool[i] = 8'($urandom_range(1, 255));
      for (int a = 0; a < NPIX; a++)
         mem[a] = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, k-1)] : 8'd0;
   endtask

   // mode: 0 ready always, 1 hold 10 cycles then toggle, 2 random ready
   task automatic run_scan(input int mode, input bit poke_start);
      int  c, stall;
      bit  fin, rdy;
      build_model();
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_sram_a", 32'(sram_a), 0);
      chk("idle_ovf_hold", 32'(overflow), 32'(prev_ovf));
      start = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      g_n = 0; c = 0; stall = 0; fin = 1'b0;
      while (!fin) begin
         @(negedge clk);
         start = poke_start && (c == 299);
         chk("sram_wen", 32'(sram_wen), 1);
         if (c <= 1023) begin
            chk("scan_addr", 32'(sram_a), 32'(c));
            chk("scan_busy", 32'(busy), 1);
            chk("scan_valid", 32'(out_valid), 0);
            chk("scan_done", 32'(done), 0);
            if (c == 0) chk("ovf_cleared", 32'(overflow), 0);
         end else if (c <= 1025) begin
            if (c == 1024) chk("drain_addr", 32'(sram_a), 1023);
            chk("drain_busy", 32'(busy), 1);
            chk("drain_valid", 32'(out_valid), 0);
            chk("drain_done", 32'(done), 0);
         end else if (g_n < e_n) begin
            chk("emit_valid", 32'(out_valid), 1);
            chk("emit_busy", 32'(busy), 1);
            chk("emit_done", 32'(done), 0);
            chk("rec_label", 32'(out_label), 32'(e_label[g_n]));
            chk("rec_count", 32'(out_count), 32'(e_cnt[g_n]));
            chk("rec_rmin", 32'(out_rmin), 32'(e_rmin[g_n]));
            chk("rec_rmax", 32'(out_rmax), 32'(e_rmax[g_n]));
            chk("rec_cmin", 32'(out_cmin), 32'(e_cmin[g_n]));
            chk("rec_cmax", 32'(out_cmax), 32'(e_cmax[g_n]));
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = (stall < 10) ? 1'b0 : (((stall - 10) % 2) == 0);
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            stall++;
            out_ready = rdy;
            if (out_valid && rdy) begin
               g_label[g_n] = out_label;
               g_cnt[g_n]   = 32'(out_count);
               g_rmin[g_n]  = 32'(out_rmin);
               g_rmax[g_n]  = 32'(out_rmax);
               g_cmin[g_n]  = 32'(out_cmin);
               g_cmax[g_n]  = 32'(out_cmax);
               g_n++;
            end
         end else begin
            chk("end_done", 32'(done), 1);
            chk("end_busy", 32'(busy), 0);
            chk("end_valid", 32'(out_valid), 0);
            chk("end_ovf", 32'(overflow), 32'(e_ovf));
            chk("end_addr", 32'(sram_a), 0);
            out_ready = 1'b0;
            fin = 1'b1;
         end
         c++;
         if (!fin && c > 1026 + 300) begin
            chk("emit_timeout", 32'(g_n), 32'(e_n));
            fin = 1'b1;
         end
      end
      @(negedge clk);
      chk("done_pulse_len", 32'(done), 0);
      chk("post_valid", 32'(out_valid), 0);
      prev_ovf = e_ovf;
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      clear_mem();
      repeat (3) @(negedge clk);
      chk("rst_sram_a", 32'(sram_a), 0);
      chk("rst_wen", 32'(sram_wen), 1);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ovf", 32'(overflow), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // All-zero image: no records, done at cycle 1026
      clear_mem();
      chk("t1_model_n", 32'(e_n), 32'(e_n));
      run_scan(0, 1'b0);
      chk("t1_nrec", 32'(g_n), 0);

      // Single 3x3 block
      clear_mem();
      fill_rect(8'h05, 2, 4, 10, 12);
      run_scan(0, 1'b0);
      chk("t2_nrec", 32'(g_n), 1);
      chk("t2_label", 32'(g_label[0]), 32'h05);
      chk("t2_count", 32'(g_cnt[0]), 9);
      chk("t2_rmin", 32'(g_rmin[0]), 2);
      chk("t2_rmax", 32'(g_rmax[0]), 4);
      chk("t2_cmin", 32'(g_cmin[0]), 10);
      chk("t2_cmax", 32'(g_cmax[0]), 12);

      // Three labels in first-appearance order 07, 02, 0A
      clear_mem();
      fill_rect(8'h07, 0, 0, 0, 4);
      fill_rect(8'h02, 1, 1, 3, 3);
      fill_rect(8'h0A, 5, 8, 20, 24);
      run_scan(2, 1'b0);
      chk("t3_nrec", 32'(g_n), 3);
      chk("t3_l0", 32'(g_label[0]), 32'h07);
      chk("t3_l1", 32'(g_label[1]), 32'h02);
      chk("t3_l2", 32'(g_label[2]), 32'h0A);
      chk("t3_c0", 32'(g_cnt[0]), 5);
      chk("t3_c1", 32'(g_cnt[1]), 1);
      chk("t3_c2", 32'(g_cnt[2]), 20);

      // Full-image label
      fill_rect(8'h01, 0, 31, 0, 31);
      run_scan(0, 1'b0);
      chk("t4_count", 32'(g_cnt[0]), 1024);
      chk("t4_rmin", 32'(g_rmin[0]), 0);
      chk("t4_rmax", 32'(g_rmax[0]), 31);
      chk("t4_cmin", 32'(g_cmin[0]), 0);
      chk("t4_cmax", 32'(g_cmax[0]), 31);

      // Stalled consumer, plus a stray start during SCAN
      clear_mem();
      fill_rect(8'h33, 0, 3, 28, 31);
      fill_rect(8'h11, 2, 9, 0, 1);
      fill_rect(8'hC0, 20, 31, 5, 6);
      fill_rect(8'h44, 12, 12, 12, 30);
      run_scan(1, 1'b1);
      chk("t5_nrec", 32'(g_n), 4);

      // MAX_OBJ+2 distinct labels
      clear_mem();
      for (int i = 0; i < MAX_OBJ + 2; i++) mem[i*100 + 7] = 8'(i + 1);
      run_scan(0, 1'b0);
      chk("t6_nrec", 32'(g_n), MAX_OBJ);
      for (int i = 0; i < MAX_OBJ; i++) chk("t6_label", 32'(g_label[i]), 32'(i + 1));
      repeat (5) @(negedge clk);
      chk("t6_ovf_sticky", 32'(overflow), 1);

      // Reset at address 500 with overflow already raised in this scan
      clear_mem();
      for (int i = 0; i < MAX_OBJ + 2; i++) mem[i] = 8'(i + 20);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      begin
         int w;
         w = 0;
         while (sram_a != 10'd500 && w < 1100) begin
            @(negedge clk);
            w++;
         end
         chk("t7_reach_500", 32'(sram_a), 500);
      end
      chk("t7_ovf_before", 32'(overflow), 1);
      reset = 1'b0;
      #1;
      chk("t7_sram_a", 32'(sram_a), 0);
      chk("t7_wen", 32'(sram_wen), 1);
      chk("t7_valid", 32'(out_valid), 0);
      chk("t7_label", 32'(out_label), 0);
      chk("t7_count", 32'(out_count), 0);
      chk("t7_box", 32'({out_rmin, out_rmax, out_cmin, out_cmax}), 0);
      chk("t7_busy", 32'(busy), 0);
      chk("t7_done", 32'(done), 0);
      chk("t7_ovf", 32'(overflow), 0);
      @(negedge clk);
      reset = 1'b1;
      prev_ovf = 1'b0;
      rand_image(6);
      run_scan(2, 1'b0);

      // Random images, some exceeding the table
      for (int t = 0; t < 6; t++) begin
         rand_image(11);
         run_scan(t % 3, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
